// File: rtl/program_loader_if.sv
// Loader bus bundle: instruction stream in, byte-wide memory write port out.
// master is the loader's view (drives in_ready and the memory request), slave is the host/memory side.
interface program_loader_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DATA_WIDTH  = 8,
  parameter int INSTR_WIDTH = 64
);
  logic                   in_valid;
  logic [INSTR_WIDTH-1:0] in_data;
  logic                   in_last;
  logic                   in_ready;
  logic                   mem_req;
  logic                   mem_we;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic                   mem_valid;

  modport master (
    input  in_valid, in_data, in_last, mem_valid,
    output in_ready, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output in_valid, in_data, in_last, mem_valid,
    input  in_ready, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/program_loader.sv
// Serializes 64-bit instructions into little-endian byte writes and appends an
// all-zero terminator word, refusing any word that would run past the top of memory.
module program_loader #(
  parameter int                    ADDR_WIDTH  = 16,
  parameter int                    DATA_WIDTH  = 8,
  parameter int                    INSTR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  program_loader_if.master      bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-3:0] instr_count
);
  localparam int NBYTES = INSTR_WIDTH / DATA_WIDTH;
  localparam int KW     = $clog2(NBYTES);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ACCEPT = 3'd1;
  localparam logic [2:0] S_WRITE  = 3'd2;
  localparam logic [2:0] S_TERM   = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]                        state;
  // Spare top bit: after the last legal word the pointer lands on 2^ADDR_WIDTH, not 0.
  logic [ADDR_WIDTH:0]               ptr;
  logic [NBYTES-1:0][DATA_WIDTH-1:0] word;
  logic                              last;
  logic [KW-1:0]                     k;

  logic [ADDR_WIDTH:0] ptr_nxt, end_cur, end_nxt;
  logic                ovf_cur, ovf_nxt, writing, last_byte, word_zero;

  assign ptr_nxt   = ptr + (ADDR_WIDTH+1)'(NBYTES);
  assign end_cur   = ptr + (ADDR_WIDTH+1)'(NBYTES-1);
  assign end_nxt   = ptr_nxt + (ADDR_WIDTH+1)'(NBYTES-1);
  assign ovf_cur   = end_cur[ADDR_WIDTH];
  assign ovf_nxt   = end_nxt[ADDR_WIDTH];
  assign writing   = (state == S_WRITE) || (state == S_TERM);
  assign last_byte = (k == KW'(NBYTES-1));
  assign word_zero = (word == '0);

  // Everything below decodes flops only, so no input reaches an output combinationally.
  assign bus.in_ready  = (state == S_ACCEPT);
  assign bus.mem_req   = writing;
  assign bus.mem_we    = writing;
  assign bus.mem_addr  = writing ? ptr[ADDR_WIDTH-1:0] + ADDR_WIDTH'(k) : '0;
  assign bus.mem_wdata = (state == S_WRITE) ? word[k] : '0;
  assign busy          = (state == S_ACCEPT) || writing;
  assign done          = (state == S_FINISH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ptr         <= '0;
      word        <= '0;
      last        <= 1'b0;
      k           <= '0;
      error       <= 1'b0;
      instr_count <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          instr_count <= '0;
          error       <= 1'b0;
          ptr         <= {1'b0, BASE_ADDR};
          state       <= S_ACCEPT;
        end
        S_ACCEPT: if (bus.in_valid) begin
          // The word is consumed even when it cannot be placed; the session then ends in error.
          if (ovf_cur) begin
            error <= 1'b1;
            state <= S_FINISH;
          end else begin
            word  <= bus.in_data;
            last  <= bus.in_last;
            k     <= '0;
            state <= S_WRITE;
          end
        end
        S_WRITE, S_TERM: if (bus.mem_valid) begin
          if (last_byte) begin
            instr_count <= instr_count + (ADDR_WIDTH-2)'(1);
            ptr         <= ptr_nxt;
            k           <= '0;
            if (state == S_TERM || word_zero) begin
              state <= S_FINISH;
            end else if (last) begin
              if (ovf_nxt) begin
                error <= 1'b1;
                state <= S_FINISH;
              end else begin
                state <= S_TERM;
              end
            end else begin
              state <= S_ACCEPT;
            end
          end else begin
            k <= k + KW'(1);
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// Drives a full-size loader and a 16-byte loader (base 8) from one shared stream and
// checks both against a word-level model of the memory image, counts and error flag.
module tb_program_loader;
  localparam int AW  = 16;
  localparam int SAW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic [63:0] in_data = '0;
  logic        mem_valid = 1'b1;
  int          mv_mode = 0;

  program_loader_if #(.ADDR_WIDTH(AW))  bi ();
  program_loader_if #(.ADDR_WIDTH(SAW)) si ();
  assign bi.in_valid = in_valid;  assign si.in_valid = in_valid;
  assign bi.in_data  = in_data;   assign si.in_data  = in_data;
  assign bi.in_last  = in_last;   assign si.in_last  = in_last;
  assign bi.mem_valid = mem_valid; assign si.mem_valid = mem_valid;

  logic busy_b, done_b, err_b, busy_s, done_s, err_s;
  logic [AW-3:0]  cnt_b;
  logic [SAW-3:0] cnt_s;

  program_loader #(.ADDR_WIDTH(AW)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bi),
    .busy(busy_b), .done(done_b), .error(err_b), .instr_count(cnt_b));

  program_loader #(.ADDR_WIDTH(SAW), .BASE_ADDR(4'd8)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(si),
    .busy(busy_s), .done(done_s), .error(err_s), .instr_count(cnt_s));

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] cap_b[int];
  logic [7:0] cap_s[int];
  int wr_b, wr_s, stall_b, stall_s, hs0, hs_cnt, done_cnt_b, done_cnt_s, done_cyc_b, done_cyc_s;
  logic [3:0]    flag_bad;
  bit            hold_pend = 0;
  logic [AW-1:0] hold_a;
  logic [7:0]    hold_d;

  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (bi.mem_req && bi.mem_valid) begin cap_b[int'(bi.mem_addr)] = bi.mem_wdata; wr_b++; end
      if (si.mem_req && si.mem_valid) begin cap_s[int'(si.mem_addr)] = si.mem_wdata; wr_s++; end
      if (bi.mem_req && !bi.mem_valid) stall_b++;
      if (si.mem_req && !si.mem_valid) stall_s++;
      if (bi.mem_we !== bi.mem_req || si.mem_we !== si.mem_req) flag_bad[0] = 1'b1;
      if (hold_pend && !(bi.mem_req && bi.mem_addr == hold_a && bi.mem_wdata == hold_d))
        flag_bad[1] = 1'b1;
      hold_pend = bi.mem_req && !bi.mem_valid;
      hold_a = bi.mem_addr;
      hold_d = bi.mem_wdata;
      if (done_b && busy_b) flag_bad[2] = 1'b1;
      if (done_s && busy_s) flag_bad[3] = 1'b1;
      if (bi.in_valid && bi.in_ready) begin if (hs0 < 0) hs0 = cyc; hs_cnt++; end
      if (done_b) begin done_cnt_b++; done_cyc_b = cyc; end
      if (done_s) begin done_cnt_s++; done_cyc_s = cyc; end
    end else begin
      hold_pend = 0;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    case (mv_mode)
      0:       mem_valid = 1'b1;
      1:       mem_valid = ~mem_valid;
      default: mem_valid = ($urandom_range(0, 3) != 0);
    endcase
  end

  // ---------------- reference model ----------------
  logic [63:0] sw[$];
  logic        sl[$];
  logic [7:0]  exp_b[int];
  logic [7:0]  exp_s[int];

  function automatic void put(input bit sm, input longint a, input logic [7:0] d);
    if (sm) exp_s[int'(a)] = d; else exp_b[int'(a)] = d;
  endfunction

  // Words go to consecutive 8-byte slots; a zero word ends the image, a last word
  // gets a zero terminator; any slot that would pass the top address is an error.
  function automatic void model(input bit sm, output int cnt, output bit err, output int acc);
    longint p, lim;
    p   = sm ? 8 : 0;
    lim = sm ? (64'd1 << SAW) - 1 : (64'd1 << AW) - 1;
    cnt = 0; err = 0; acc = 0;
    if (sm) exp_s.delete(); else exp_b.delete();
    foreach (sw[i]) begin
      acc++;
      if (p + 7 > lim) begin err = 1; return; end
      for (int b = 0; b < 8; b++) put(sm, p + b, sw[i][8*b +: 8]);
      cnt++; p += 8;
      if (sw[i] == 64'd0) return;
      if (sl[i]) begin
        if (p + 7 > lim) begin err = 1; return; end
        for (int b = 0; b < 8; b++) put(sm, p + b, 8'h00);
        cnt++;
        return;
      end
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic present(input logic [63:0] w, input logic l, output bit ok);
    int n = 0;
    in_valid = 1'b1; in_data = w; in_last = l;
    while (!bi.in_ready && n < 500) begin tick(); n++; end
    ok = bi.in_ready;
    tick();
    in_valid = 1'b0;
    chk("handshake", 64'(ok), 64'd1);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_in_ready"}, 64'(bi.in_ready), 0);
    chk({tag, "_mem_req"},  64'(bi.mem_req), 0);
    chk({tag, "_mem_we"},   64'(bi.mem_we), 0);
    chk({tag, "_mem_addr"}, 64'(bi.mem_addr), 0);
    chk({tag, "_mem_wdata"}, 64'(bi.mem_wdata), 0);
    chk({tag, "_busy"},  64'(busy_b), 0);
    chk({tag, "_done"},  64'(done_b), 0);
    chk({tag, "_error"}, 64'(err_b), 0);
    chk({tag, "_count"}, 64'(cnt_b), 0);
    chk({tag, "_s_mem_req"}, 64'(si.mem_req), 0);
    chk({tag, "_s_busy"},  64'(busy_s), 0);
    chk({tag, "_s_count"}, 64'(cnt_s), 0);
  endtask

  task automatic run_session(input int mode, input bit glitch);
    int  ecnt_b, ecnt_s, acc_b, acc_s, waitc;
    bit  eerr_b, eerr_s, ok;
    model(0, ecnt_b, eerr_b, acc_b);
    model(1, ecnt_s, eerr_s, acc_s);
    mv_mode = mode;
    cap_b.delete(); cap_s.delete();
    wr_b = 0; wr_s = 0; stall_b = 0; stall_s = 0; hs0 = -1; hs_cnt = 0;
    done_cnt_b = 0; done_cnt_s = 0; flag_bad = '0;
    start = 1'b1; tick(); start = 1'b0;
    chk("in_ready_after_start", 64'(bi.in_ready), 1);
    chk("busy_after_start", 64'(busy_b), 1);
    chk("count_cleared", 64'(cnt_b), 0);
    chk("s_count_cleared", 64'(cnt_s), 0);
    chk("s_error_cleared", 64'(err_s), 0);
    for (int i = 0; i < acc_b; i++) begin
      if (mode == 2) repeat ($urandom_range(0, 2)) tick();
      present(sw[i], sl[i], ok);
      if (!ok) break;
      if (glitch && i == 0) begin
        repeat (3) tick();
        start = 1'b1; tick(); start = 1'b0;
      end
    end
    waitc = 0;
    while (done_cnt_b == 0 && waitc < 1000) begin tick(); waitc++; end
    repeat (3) tick();
    chk("done_once", 64'(done_cnt_b), 1);
    chk("s_done_once", 64'(done_cnt_s), 1);
    chk("handshakes", 64'(hs_cnt), 64'(acc_b));
    chk("instr_count", 64'(cnt_b), 64'(ecnt_b));
    chk("error", 64'(err_b), 64'(eerr_b));
    chk("s_instr_count", 64'(cnt_s), 64'(ecnt_s));
    chk("s_error", 64'(err_s), 64'(eerr_s));
    chk("writes", 64'(wr_b), 64'(exp_b.num()));
    chk("s_writes", 64'(wr_s), 64'(exp_s.num()));
    foreach (exp_b[a])
      chk($sformatf("mem[%0d]", a), cap_b.exists(a) ? 64'(cap_b[a]) : 64'hBAD, 64'(exp_b[a]));
    foreach (exp_s[a])
      chk($sformatf("s_mem[%0d]", a), cap_s.exists(a) ? 64'(cap_s[a]) : 64'hBAD, 64'(exp_s[a]));
    chk("bus_rules", 64'(flag_bad), 0);
    chk("in_ready_after_done", 64'(bi.in_ready), 0);
    chk("busy_after_done", 64'(busy_b), 0);
    chk("s_busy_after_done", 64'(busy_s), 0);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [63:0] w0, w1;
    logic        l0, l1;
    int          nw, mode;
    bit          glitch;
    int          cnt_b;  bit err_b;  int lat_b;
    int          cnt_s;  bit err_s;  int lat_s;
  } vec_t;

  vec_t tv[5];

  initial begin
    bit ok;
    int n, nw;
    logic [63:0] w;

    tv[0] = '{64'h0102030405060708, 64'h1111111111111111, 1'b0, 1'b1, 2, 0, 1'b0, 3, 1'b0, 26, 1, 1'b1, 10};
    tv[1] = '{64'h0102030405060708, 64'h1111111111111111, 1'b0, 1'b1, 2, 1, 1'b0, 3, 1'b0, 26, 1, 1'b1, 10};
    tv[2] = '{64'h0, 64'h0, 1'b0, 1'b0, 1, 0, 1'b0, 1, 1'b0, 9, 1, 1'b0, 9};
    tv[3] = '{64'hDEADBEEF00C0FFEE, 64'h0, 1'b1, 1'b0, 1, 0, 1'b0, 2, 1'b0, 17, 1, 1'b1, 9};
    tv[4] = '{64'h0102030405060708, 64'h1111111111111111, 1'b0, 1'b1, 2, 0, 1'b1, 3, 1'b0, 26, 1, 1'b1, 10};

    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    @(negedge clk) rst_n = 1'b1;
    tick();

    foreach (tv[t]) begin
      sw.delete(); sl.delete();
      sw.push_back(tv[t].w0); sl.push_back(tv[t].l0);
      if (tv[t].nw == 2) begin sw.push_back(tv[t].w1); sl.push_back(tv[t].l1); end
      run_session(tv[t].mode, tv[t].glitch);
      chk($sformatf("v%0d_count", t), 64'(cnt_b), 64'(tv[t].cnt_b));
      chk($sformatf("v%0d_error", t), 64'(err_b), 64'(tv[t].err_b));
      chk($sformatf("v%0d_latency", t), 64'(done_cyc_b - hs0), 64'(tv[t].lat_b + stall_b));
      chk($sformatf("v%0d_s_count", t), 64'(cnt_s), 64'(tv[t].cnt_s));
      chk($sformatf("v%0d_s_error", t), 64'(err_s), 64'(tv[t].err_s));
      chk($sformatf("v%0d_s_latency", t), 64'(done_cyc_s - hs0), 64'(tv[t].lat_s + stall_s));
    end
    chk("v0_mem0", cap_b.exists(0) ? 64'(cap_b[0]) : 64'hBAD, 64'h08);

    // Reset in the middle of byte 3, then a clean reload of the same stream.
    sw.delete(); sl.delete();
    sw.push_back(64'hA5A55A5A0F0FF0F0); sl.push_back(1'b1);
    mv_mode = 0;
    start = 1'b1; tick(); start = 1'b0;
    present(sw[0], 1'b1, ok);
    n = 0;
    while (!(bi.mem_req && bi.mem_addr == 16'd3) && n < 50) begin tick(); n++; end
    chk("reached_byte3", 64'(bi.mem_addr), 3);
    rst_n = 1'b0;
    #1;
    check_reset("mid_reset");
    @(negedge clk) rst_n = 1'b1;
    tick();
    run_session(0, 1'b0);

    // Random streams, each ending in either a last-flagged word or a zero word.
    for (int s = 0; s < 12; s++) begin
      nw = $urandom_range(1, 4);
      sw.delete(); sl.delete();
      for (int i = 0; i < nw; i++) begin
        w = {$urandom, $urandom};
        if ($urandom_range(0, 5) == 0) w = '0;
        sw.push_back(w);
        sl.push_back((i == nw - 1) ? ($urandom_range(0, 3) != 0) : 1'b0);
      end
      if (!sl[nw-1]) sw[nw-1] = '0;
      run_session($urandom_range(0, 2), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
